axichannel_replayer: RTL and testbench

Replay-side counterpart of the AXI channel logger. Accepts logged channel beats streamed back from the storage backend through a register pipeline, buffers them in a small FIFO, and re-drives them onto one AXI-style valid/ready channel in original order. Sits between the replay storage backend and the replayed channel's consumer. Reports each completed beat back to the backend as a pipelined end-of-transaction pulse.

---
 rtl/axichannel_replayer.sv | 171 +++++++++++++++++
 tb/tb_axichannel_replayer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axichannel_replayer.sv
`default_nettype none
// ============================================================================
// Module   : axichannel_replayer
// Purpose  : Re-drives logged channel beats from the replay backend onto one
//            valid/ready channel, with FIFO buffering and pipelined almful /
//            end-of-beat reporting. Optional debug counters: RPLY_DEBUG_CNT_EN
// Revision : 1.0 - initial release
// ============================================================================
module axichannel_replayer #(
  parameter int DATA_WIDTH = 32,
  parameter int PIPE_DEPTH = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rplb_valid,
  input  logic [DATA_WIDTH-1:0] rplb_data,
  output logic                  rplb_almful,
  input  logic                  replay_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  rple_valid,
  output logic                  err_overflow
`ifdef RPLY_DEBUG_CNT_EN
  ,
  output logic [31:0]           dbg_beat_cnt,
  output logic [31:0]           dbg_stall_cnt
`endif
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam logic [c_CW-1:0] c_FULL   = c_CW'(FIFO_DEPTH);
  localparam logic [c_CW-1:0] c_THRESH = c_CW'(FIFO_DEPTH - (2*PIPE_DEPTH + 2));

  logic                  w_in_vld;
  logic [DATA_WIDTH-1:0] w_in_dat;
  logic                  w_hs;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_full;

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]       r_wptr;
  logic [c_AW-1:0]       r_rptr;
  logic [c_CW-1:0]       r_cnt;
  logic                  r_almful;
  logic                  r_out_vld;
  logic [DATA_WIDTH-1:0] r_out_dat;
  logic                  r_ovf;

  assign w_hs   = r_out_vld && out_ready;
  assign w_full = (r_cnt == c_FULL);
  assign w_wr   = w_in_vld && !w_full;
  assign w_rd   = (!r_out_vld || out_ready) && (r_cnt != '0) && replay_en;

  generate
    if (PIPE_DEPTH == 0) begin : g_nopipe
      assign w_in_vld    = rplb_valid;
      assign w_in_dat    = rplb_data;
      assign rplb_almful = r_almful;
      assign rple_valid  = w_hs;
    end else begin : g_pipe
      logic [PIPE_DEPTH-1:0] r_in_vld;
      logic [PIPE_DEPTH-1:0] r_alm;
      logic [PIPE_DEPTH-1:0] r_end;
      logic [DATA_WIDTH-1:0] r_in_dat [PIPE_DEPTH];

      always_ff @(posedge clk) begin
        if (!rstn) begin
          r_in_vld <= '0;
          r_alm    <= '0;
          r_end    <= '0;
        end else begin
          r_in_vld[0] <= rplb_valid;
          r_alm[0]    <= r_almful;
          r_end[0]    <= w_hs;
          for (int i = 1; i < PIPE_DEPTH; i++) begin
            r_in_vld[i] <= r_in_vld[i-1];
            r_alm[i]    <= r_alm[i-1];
            r_end[i]    <= r_end[i-1];
          end
        end
      end

      // Payload stages carry no reset; their valid bits qualify them.
      always_ff @(posedge clk) begin
        r_in_dat[0] <= rplb_data;
        for (int i = 1; i < PIPE_DEPTH; i++) begin
          r_in_dat[i] <= r_in_dat[i-1];
        end
      end

      assign w_in_vld    = r_in_vld[PIPE_DEPTH-1];
      assign w_in_dat    = r_in_dat[PIPE_DEPTH-1];
      assign rplb_almful = r_alm[PIPE_DEPTH-1];
      assign rple_valid  = r_end[PIPE_DEPTH-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= w_in_dat;
    end
    if (w_rd) begin
      r_out_dat <= r_mem[r_rptr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_cnt     <= '0;
      r_almful  <= 1'b0;
      r_out_vld <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + c_AW'(1);
      end
      if (w_rd) begin
        r_rptr <= r_rptr + c_AW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + c_CW'(1);
        2'b01:   r_cnt <= r_cnt - c_CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      // Margin of 2*PIPE_DEPTH+2 absorbs every beat still in flight.
      r_almful <= (r_cnt >= c_THRESH);
      if (w_rd) begin
        r_out_vld <= 1'b1;
      end else if (w_hs) begin
        r_out_vld <= 1'b0;
      end
      if (w_in_vld && w_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign out_valid    = r_out_vld;
  assign out_data     = r_out_dat;
  assign err_overflow = r_ovf;

`ifdef RPLY_DEBUG_CNT_EN
  logic [31:0] r_beat_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_beat_cnt  <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_hs) begin
        r_beat_cnt <= r_beat_cnt + 32'd1;
      end
      if (r_out_vld && !out_ready) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign dbg_beat_cnt  = r_beat_cnt;
  assign dbg_stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axichannel_replayer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axichannel_replayer
// Purpose  : Scoreboard bench for axichannel_replayer (PIPE_DEPTH=4, FIFO=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axichannel_replayer;
  localparam int DW = 32;
  localparam int PD = 4;
  localparam int FD = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          rplb_valid = 1'b0;
  logic [DW-1:0] rplb_data = '0;
  logic          replay_en = 1'b0;
  logic          out_ready = 1'b0;
  logic          rplb_almful;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          rple_valid;
  logic          err_overflow;
`ifdef RPLY_DEBUG_CNT_EN
  logic [31:0]   dbg_beat_cnt;
  logic [31:0]   dbg_stall_cnt;
`endif

  axichannel_replayer #(.DATA_WIDTH(DW), .PIPE_DEPTH(PD), .FIFO_DEPTH(FD)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .rplb_valid   (rplb_valid),
    .rplb_data    (rplb_data),
    .rplb_almful  (rplb_almful),
    .replay_en    (replay_en),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .rple_valid   (rple_valid),
    .err_overflow (err_overflow)
`ifdef RPLY_DEBUG_CNT_EN
    ,
    .dbg_beat_cnt (dbg_beat_cnt),
    .dbg_stall_cnt(dbg_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] exp_q[$];
  int            hs_cnt = 0;
  int            rple_cnt = 0;
  logic          held = 1'b0;
  logic [DW-1:0] held_dat = '0;
  bit            rand_done = 1'b0;
  int            rand_sent = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every handshake and checks AXI hold.
  always @(negedge clk) begin
    if (rstn) begin
      if (held) begin
        chk1("hold_valid", out_valid, 1'b1);
        chk("hold_data", out_data, held_dat);
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL beat_data: got %0h want none (scoreboard empty)", out_data);
        end else begin
          chk("beat_data", out_data, exp_q.pop_front());
        end
      end
      if (rple_valid) rple_cnt++;
      held     = out_valid && !out_ready;
      held_dat = out_data;
    end else begin
      held = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input bit keep);
    rplb_valid = 1'b1;
    rplb_data  = d;
    if (keep) exp_q.push_back(d);
    tick();
    rplb_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s: drain timeout, got %0d beats outstanding want 0", name, exp_q.size());
    end
    repeat (PD + 2) tick();
  endtask

  // Beat sampled at edge s: out_valid in cycle s+PD+1 only, rple in s+2*PD+1 only.
  task automatic single_beat(input logic [DW-1:0] d, input string tag);
    send(d, 1'b1);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      chk1({tag, "_valid"}, out_valid, k == PD + 1);
      chk1({tag, "_rple"}, rple_valid, k == 2*PD + 1);
      if (k == PD + 1) chk({tag, "_data"}, out_data, d);
      tick();
    end
  endtask

  initial begin
    int b_hs;
    int b_rp;
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  initial begin
    int b_hs;
    int b_rp;
    repeat (3) tick();
    @(negedge clk);
    chk1("rst_valid", out_valid, 1'b0);
    chk1("rst_almful", rplb_almful, 1'b0);
    chk1("rst_rple", rple_valid, 1'b0);
    chk1("rst_ovf", err_overflow, 1'b0);
    tick();
    rstn = 1'b1;
    replay_en = 1'b1;
    out_ready = 1'b1;
    repeat (3) tick();

    // Single beat latency
    b_hs = hs_cnt;
    b_rp = rple_cnt;
    single_beat(32'hA5, "s1");
    chk("s1_hs", hs_cnt - b_hs, 1);
    chk("s1_rple", rple_cnt - b_rp, 1);

    // 16 beats with consumer stalled: almful rises after edge s+15
    out_ready = 1'b0;
    for (int k = 0; k < 21; k++) begin
      if (k < 16) begin
        rplb_valid = 1'b1;
        rplb_data  = k;
        exp_q.push_back(k);
      end
      @(posedge clk);
      #1;
      rplb_valid = 1'b0;
      @(negedge clk);
      chk1("s2_almful", rplb_almful, k >= 15);
    end
    chk1("s2_ovf", err_overflow, 1'b0);
    out_ready = 1'b1;
    wait_drain("s2", 200);
    chk1("s2_ovf_end", err_overflow, 1'b0);

    // Presented beat held across replay_en drop
    out_ready = 1'b0;
    send(32'h31, 1'b1);
    send(32'h32, 1'b1);
    send(32'h33, 1'b1);
    repeat (PD) tick();
    replay_en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk1("s3_hold_valid", out_valid, 1'b1);
      chk("s3_hold_data", out_data, 32'h31);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk1("s3_hs_valid", out_valid, 1'b1);
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("s3_blocked", out_valid, 1'b0);
      tick();
    end
    replay_en = 1'b1;
    tick();
    @(negedge clk);
    chk1("s3_resume_valid", out_valid, 1'b1);
    chk("s3_resume_data", out_data, 32'h32);
    tick();
    wait_drain("s3", 100);

    // Random ready, backend honours almful
    b_hs = hs_cnt;
    b_rp = rple_cnt;
    fork
      begin
        int guard = 0;
        while (rand_sent < 1000 && guard < 20000) begin
          if (!rplb_almful) begin
            rplb_valid = 1'b1;
            rplb_data  = 32'h1000 + rand_sent;
            exp_q.push_back(32'h1000 + rand_sent);
            rand_sent++;
          end else begin
            rplb_valid = 1'b0;
          end
          tick();
          guard++;
        end
        rplb_valid = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
        end
        out_ready = 1'b1;
      end
    join
    chk("s4_sent", rand_sent, 1000);
    wait_drain("s4", 500);
    chk("s4_hs", hs_cnt - b_hs, 1000);
    chk("s4_rple", rple_cnt - b_rp, 1000);
    chk1("s4_ovf", err_overflow, 1'b0);

    // Overflow: only the first 16 beats fit
    replay_en = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 40; i++) send(32'h200 + i, i < 16);
    repeat (PD + 2) tick();
    @(negedge clk);
    chk1("s5_ovf", err_overflow, 1'b1);
    chk1("s5_valid", out_valid, 1'b0);
    tick();
    replay_en = 1'b1;
    out_ready = 1'b1;
    wait_drain("s5", 200);
    chk1("s5_ovf_sticky", err_overflow, 1'b1);
    rstn = 1'b0;
    exp_q.delete();
    tick();
    rstn = 1'b1;
    @(negedge clk);
    chk1("s5_ovf_clr", err_overflow, 1'b0);
    tick();

    // Reset mid-stream with beats in pipe, FIFO and end-pulse pipe
    for (int i = 0; i < 8; i++) send(32'h300 + i, 1'b1);
    rstn = 1'b0;
    exp_q.delete();
    rplb_valid = 1'b1;
    rplb_data  = 32'h3FF;
    tick();
    rstn = 1'b1;
    rplb_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk1("s6_valid", out_valid, 1'b0);
      chk1("s6_almful", rplb_almful, 1'b0);
      chk1("s6_rple", rple_valid, 1'b0);
      tick();
    end
    single_beat(32'hC3, "s6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
